// File: rtl/snell_pkg.sv
// Shared constants and state encoding for the Snell's-law angle datapath.
package snell_pkg;

    localparam int ANGLE_W = 7;                      // angle width, integer degrees
    localparam int SINE_W  = 9;                      // sine magnitude width, unsigned Q1.8
    localparam int IDX_W   = $clog2(ANGLE_W);        // bit index counter width

    localparam logic [ANGLE_W-1:0] MAX_ANGLE    = 7'd90;   // largest legal angle
    localparam logic [SINE_W-1:0]  SINE_ONE     = 9'd256;  // encoding of sin = 1.0
    localparam logic [SINE_W-1:0]  SINE_INVALID = 9'h1FF;  // table value for angles > MAX_ANGLE

    // Controller states, kept as plain constants so the encoding is fixed and visible.
    typedef logic [1:0] state_t;
    localparam state_t IDLE   = 2'd0;
    localparam state_t SEARCH = 2'd1;
    localparam state_t ERR    = 2'd2;

endpackage

// File: rtl/asin_sine_lut.sv
// Combinational sine table: round(256*sin(angle deg)) for 0..90 degrees.
// Angles beyond 90 return an all-ones value larger than any legal sine,
// so a search candidate that overshoots the range is always rejected.
module asin_sine_lut
    import snell_pkg::*;
(
    input  logic [ANGLE_W-1:0] angle,
    output logic [SINE_W-1:0]  sin
);

    // Table lookup; out-of-range angles map to the invalid marker.
    always_comb begin
        // NOTE: default assignment first so no path leaves sin unassigned (no latch).
        sin = SINE_INVALID;
        case (angle)
            7'd0:  sin = 9'd0;    7'd1:  sin = 9'd4;    7'd2:  sin = 9'd9;    7'd3:  sin = 9'd13;
            7'd4:  sin = 9'd18;   7'd5:  sin = 9'd22;   7'd6:  sin = 9'd27;   7'd7:  sin = 9'd31;
            7'd8:  sin = 9'd36;   7'd9:  sin = 9'd40;   7'd10: sin = 9'd44;   7'd11: sin = 9'd49;
            7'd12: sin = 9'd53;   7'd13: sin = 9'd58;   7'd14: sin = 9'd62;   7'd15: sin = 9'd66;
            7'd16: sin = 9'd71;   7'd17: sin = 9'd75;   7'd18: sin = 9'd79;   7'd19: sin = 9'd83;
            7'd20: sin = 9'd88;   7'd21: sin = 9'd92;   7'd22: sin = 9'd96;   7'd23: sin = 9'd100;
            7'd24: sin = 9'd104;  7'd25: sin = 9'd108;  7'd26: sin = 9'd112;  7'd27: sin = 9'd116;
            7'd28: sin = 9'd120;  7'd29: sin = 9'd124;  7'd30: sin = 9'd128;  7'd31: sin = 9'd132;
            7'd32: sin = 9'd136;  7'd33: sin = 9'd139;  7'd34: sin = 9'd143;  7'd35: sin = 9'd147;
            7'd36: sin = 9'd150;  7'd37: sin = 9'd154;  7'd38: sin = 9'd158;  7'd39: sin = 9'd161;
            7'd40: sin = 9'd165;  7'd41: sin = 9'd168;  7'd42: sin = 9'd171;  7'd43: sin = 9'd175;
            7'd44: sin = 9'd178;  7'd45: sin = 9'd181;  7'd46: sin = 9'd184;  7'd47: sin = 9'd187;
            7'd48: sin = 9'd190;  7'd49: sin = 9'd193;  7'd50: sin = 9'd196;  7'd51: sin = 9'd199;
            7'd52: sin = 9'd202;  7'd53: sin = 9'd204;  7'd54: sin = 9'd207;  7'd55: sin = 9'd210;
            7'd56: sin = 9'd212;  7'd57: sin = 9'd215;  7'd58: sin = 9'd217;  7'd59: sin = 9'd219;
            7'd60: sin = 9'd222;  7'd61: sin = 9'd224;  7'd62: sin = 9'd226;  7'd63: sin = 9'd228;
            7'd64: sin = 9'd230;  7'd65: sin = 9'd232;  7'd66: sin = 9'd234;  7'd67: sin = 9'd236;
            7'd68: sin = 9'd237;  7'd69: sin = 9'd239;  7'd70: sin = 9'd241;  7'd71: sin = 9'd242;
            7'd72: sin = 9'd243;  7'd73: sin = 9'd245;  7'd74: sin = 9'd246;  7'd75: sin = 9'd247;
            7'd76: sin = 9'd248;  7'd77: sin = 9'd249;  7'd78: sin = 9'd250;  7'd79: sin = 9'd251;
            7'd80: sin = 9'd252;  7'd81: sin = 9'd253;  7'd82: sin = 9'd254;  7'd83: sin = 9'd254;
            7'd84: sin = 9'd255;  7'd85: sin = 9'd255;  7'd86: sin = 9'd255;  7'd87: sin = 9'd256;
            7'd88: sin = 9'd256;  7'd89: sin = 9'd256;  7'd90: sin = 9'd256;
            default: sin = SINE_INVALID;
        endcase
    end

endmodule

// File: rtl/arcsine.sv
// Arcsine: recovers an integer angle (0..90 deg) from a Q1.8 sine magnitude.
// Bitwise binary search, MSB first, one bit per clock: the result is the
// largest angle whose table sine does not exceed the input. Inputs above 1.0
// are flagged as out of domain and answered with MAX_ANGLE after one cycle.
module arcsine
    import snell_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [SINE_W-1:0]  s,
    output logic               busy,
    output logic               done,
    output logic [ANGLE_W-1:0] theta,
    output logic               err
);

    state_t             state;
    logic [SINE_W-1:0]  s_reg;
    logic [ANGLE_W-1:0] cand;
    logic [IDX_W-1:0]   bit_idx;

    logic [ANGLE_W-1:0] trial;
    logic [SINE_W-1:0]  trial_sin;
    logic               accept;
    logic [ANGLE_W-1:0] cand_next;

    asin_sine_lut u_lut (
        .angle (trial),
        .sin   (trial_sin)
    );

    // Trial candidate for the current bit and the accept decision for it.
    always_comb begin
        trial     = cand | (ANGLE_W'(1) << bit_idx);
        accept    = (trial <= MAX_ANGLE) && (trial_sin <= s_reg);
        cand_next = accept ? trial : cand;
    end

    // Controller, search registers and held result outputs.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register updates from pre-edge values.
        if (rst) begin
            state   <= IDLE;
            s_reg   <= '0;
            cand    <= '0;
            bit_idx <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            theta   <= '0;
            err     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        s_reg   <= s;
                        cand    <= '0;
                        bit_idx <= IDX_W'(ANGLE_W - 1);
                        busy    <= 1'b1;
                        state   <= (s > SINE_ONE) ? ERR : SEARCH;
                    end
                end
                SEARCH: begin
                    cand <= cand_next;
                    if (bit_idx == '0) begin
                        theta <= cand_next;
                        err   <= 1'b0;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        bit_idx <= bit_idx - 1'b1;
                    end
                end
                ERR: begin
                    theta <= MAX_ANGLE;
                    err   <= 1'b1;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
